// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared fetch-stage types, special instruction words and address helpers
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // Instruction RAM is word addressed; the byte PC is always word aligned.
  function automatic logic [31:0] fetch_index(input logic [31:0] pc);
    return pc >> 2;
  endfunction

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// rtl/instruction_fetch_if_id_reg.sv - IF/ID pipeline register with squash, hold and load
// Priority is squash over hold over load; squash clears only the valid bit.
module if_id_reg
  import instruction_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        squash,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc4,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= NOP_WORD;
      pc4   <= 32'h0000_0000;
      valid <= 1'b0;
    end else if (squash) begin
      valid <= 1'b0;
    end else if (load && !hold) begin
      instr <= load_instr;
      pc4   <= load_pc4;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC, RUN/DRAIN/HALTED control and IF/ID register of the fetch stage
// Define IFETCH_PERF_CNT_EN to add the FETCH_COUNT output counting IF/ID loads.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        STALL,
  input  logic        REDIRECT_VALID,
  input  logic [31:0] REDIRECT_TARGET,
  input  logic [31:0] DATA,
  output logic [31:0] FETCH_ADDRESS,
  output logic        stop,
  output logic [31:0] IF_INSTR,
  output logic [31:0] IF_PC4,
  output logic        IF_VALID,
`ifdef IFETCH_PERF_CNT_EN
  output logic        CPU_HALTED,
  output logic [31:0] FETCH_COUNT
`else
  output logic        CPU_HALTED
`endif
);

  localparam int CNT_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((DRAIN_CYCLES > 1) ? DRAIN_CYCLES - 1 : 0);

  fetch_state_t     state;
  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] drain_cnt;
  logic             is_halt_word;
  logic             ifid_squash;
  logic             ifid_load;

  always_comb begin
    pc_plus4     = pc + 32'd4;
    redirect_pc  = word_align(REDIRECT_TARGET);
    is_halt_word = (DATA == HALT_WORD);
    // Outside RUN the slot is always emptied; in RUN a stall only wins over a halt word.
    ifid_squash  = (state != RUN) || REDIRECT_VALID || (!STALL && is_halt_word);
    ifid_load    = (state == RUN) && !REDIRECT_VALID && !STALL && !is_halt_word;
  end

  assign FETCH_ADDRESS = fetch_index(pc);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= RUN;
      pc         <= word_align(RESET_PC);
      drain_cnt  <= '0;
      stop       <= 1'b0;
      CPU_HALTED <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (REDIRECT_VALID) begin
            pc <= redirect_pc;
          end else if (!STALL) begin
            if (is_halt_word) begin
              state     <= DRAIN;
              drain_cnt <= '0;
              stop      <= 1'b1;
            end else begin
              pc <= pc_plus4;
            end
          end
        end
        DRAIN: begin
          // A redirect means the halt word was fetched down a mispredicted path.
          if (REDIRECT_VALID) begin
            state     <= RUN;
            pc        <= redirect_pc;
            drain_cnt <= '0;
            stop      <= 1'b0;
          end else if (drain_cnt == DRAIN_LAST) begin
            state      <= HALTED;
            CPU_HALTED <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        HALTED: begin
          stop       <= 1'b1;
          CPU_HALTED <= 1'b1;
        end
        default: begin
          state      <= HALTED;
          stop       <= 1'b1;
          CPU_HALTED <= 1'b1;
        end
      endcase
    end
  end

  if_id_reg u_if_id (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .squash     (ifid_squash),
    .hold       (STALL),
    .load       (ifid_load),
    .load_instr (DATA),
    .load_pc4   (pc_plus4),
    .instr      (IF_INSTR),
    .pc4        (IF_PC4),
    .valid      (IF_VALID)
  );

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      FETCH_COUNT <= 32'h0000_0000;
    end else if (ifid_load) begin
      FETCH_COUNT <= FETCH_COUNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized and directed checks of instruction_fetch against a behavioural model
module tb_instruction_fetch;

  localparam int DRAIN = 4;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        STALL = 1'b0;
  logic        REDIRECT_VALID = 1'b0;
  logic [31:0] REDIRECT_TARGET = '0;
  logic [31:0] DATA;
  logic [31:0] FETCH_ADDRESS, IF_INSTR, IF_PC4;
  logic        stop, IF_VALID, CPU_HALTED;
  logic [31:0] w_addr, w_instr, w_pc4, w_data;
  logic        w_stop, w_valid, w_halted;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] FETCH_COUNT, w_count;
`endif

  logic [31:0] mem [64];

  always #5 CLK = ~CLK;

  assign DATA   = mem[FETCH_ADDRESS[5:0]];
  assign w_data = {w_addr[15:0], 16'hA5A5};

  instruction_fetch #(.RESET_PC(32'h0000_0000), .DRAIN_CYCLES(DRAIN)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .STALL(STALL), .REDIRECT_VALID(REDIRECT_VALID),
    .REDIRECT_TARGET(REDIRECT_TARGET), .DATA(DATA), .FETCH_ADDRESS(FETCH_ADDRESS),
    .stop(stop), .IF_INSTR(IF_INSTR), .IF_PC4(IF_PC4), .IF_VALID(IF_VALID),
`ifdef IFETCH_PERF_CNT_EN
    .CPU_HALTED(CPU_HALTED), .FETCH_COUNT(FETCH_COUNT)
`else
    .CPU_HALTED(CPU_HALTED)
`endif
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .DRAIN_CYCLES(2)) u_wrap (
    .CLK(CLK), .RESET_N(RESET_N), .STALL(1'b0), .REDIRECT_VALID(1'b0),
    .REDIRECT_TARGET(32'h0), .DATA(w_data), .FETCH_ADDRESS(w_addr),
    .stop(w_stop), .IF_INSTR(w_instr), .IF_PC4(w_pc4), .IF_VALID(w_valid),
`ifdef IFETCH_PERF_CNT_EN
    .CPU_HALTED(w_halted), .FETCH_COUNT(w_count)
`else
    .CPU_HALTED(w_halted)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_pc, m_instr, m_pc4, m_fetches;
  bit          m_valid, m_draining, m_halted;
  int          m_drain_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_fetches = 32'h0;
    m_valid = 0; m_draining = 0; m_halted = 0; m_drain_seen = 0;
  endtask

  task automatic model_step(input bit s, input bit r, input logic [31:0] t, input logic [31:0] d);
    if (m_halted) return;
    if (m_draining) begin
      m_valid = 0;
      if (r) begin
        m_pc = t & ~32'd3;
        m_draining = 0;
      end else begin
        m_drain_seen++;
        if (m_drain_seen >= DRAIN) begin
          m_halted = 1;
          m_draining = 0;
        end
      end
    end else if (r) begin
      m_pc = t & ~32'd3;
      m_valid = 0;
    end else if (!s) begin
      if (d == 32'hFFFF_FFFF) begin
        m_valid = 0;
        m_draining = 1;
        m_drain_seen = 0;
      end else begin
        m_instr = d;
        m_pc4 = m_pc + 32'd4;
        m_pc = m_pc + 32'd4;
        m_valid = 1;
        m_fetches++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".addr"}, FETCH_ADDRESS, m_pc / 4);
    check({tag, ".instr"}, IF_INSTR, m_instr);
    check({tag, ".pc4"}, IF_PC4, m_pc4);
    check({tag, ".valid"}, {31'b0, IF_VALID}, {31'b0, m_valid});
    check({tag, ".stop"}, {31'b0, stop}, {31'b0, m_draining || m_halted});
    check({tag, ".halted"}, {31'b0, CPU_HALTED}, {31'b0, m_halted});
`ifdef IFETCH_PERF_CNT_EN
    check({tag, ".count"}, FETCH_COUNT, m_fetches);
`endif
  endtask

  task automatic step(input string tag, input bit s, input bit r, input logic [31:0] t);
    STALL = s; REDIRECT_VALID = r; REDIRECT_TARGET = t;
    @(posedge CLK);
    model_step(s, r, t, mem[m_pc[7:2]]);
    @(negedge CLK);
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 1'b0; STALL = 1'b0; REDIRECT_VALID = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    @(negedge CLK);
    RESET_N = 1'b1;
    check_all("rst_rel");
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;

    // Free-running fetch, stall hold, redirect under stall; wrap-around on the second instance.
    do_reset();
    check("wrap.addr0", w_addr, 32'h3FFF_FFFE);
    step("run0", 0, 0, 0);
    check("wrap.pc4_1", w_pc4, 32'hFFFF_FFFC);
    check("wrap.addr1", w_addr, 32'h3FFF_FFFF);
    step("run1", 0, 0, 0);
    check("wrap.pc4_2", w_pc4, 32'h0000_0000);
    check("wrap.instr2", w_instr, 32'hFFFF_A5A5);
    check("wrap.addr2", w_addr, 32'h0000_0000);
    check("run1.instr_b", IF_INSTR, 32'h1000_0001);
    step("stall0", 1, 0, 0);
    step("stall1", 1, 0, 0);
    check("stall.addr", FETCH_ADDRESS, 32'd2);
    check("stall.instr", IF_INSTR, 32'h1000_0001);
    step("resume", 0, 0, 0);
    check("resume.pc4", IF_PC4, 32'd12);
    check("resume.instr_c", IF_INSTR, 32'h1000_0002);
    step("redir", 1, 1, 32'h0000_0043);
    check("redir.addr", FETCH_ADDRESS, 32'd16);
    check("redir.valid", {31'b0, IF_VALID}, 32'd0);
    step("redir_next", 0, 0, 0);
    check("redir_next.instr", IF_INSTR, 32'h1000_0010);

    // Halt word at index 5: drain then terminal halt.
    mem[5] = 32'hFFFF_FFFF;
    do_reset();
    for (int i = 0; i < 5; i++) step("pre_halt", 0, 0, 0);
    step("halt_edge", 0, 0, 0);
    check("halt_edge.stop", {31'b0, stop}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step("draining", 0, 0, 0);
      check("draining.halted", {31'b0, CPU_HALTED}, 32'd0);
    end
    step("halt_done", 0, 0, 0);
    check("halt_done.halted", {31'b0, CPU_HALTED}, 32'd1);
    step("halted_redir", 1, 1, 32'h40);
    step("halted_run", 0, 0, 0);

    // Wrong-path halt: redirect during second drain cycle.
    do_reset();
    for (int i = 0; i < 6; i++) step("pre_halt2", 0, 0, 0);
    step("drain2", 0, 0, 0);
    step("drain_redir", 0, 1, 32'h80);
    check("drain_redir.stop", {31'b0, stop}, 32'd0);
    check("drain_redir.addr", FETCH_ADDRESS, 32'd32);
    for (int i = 0; i < 6; i++) step("post_redir", 0, 0, 0);
    check("post_redir.halted", {31'b0, CPU_HALTED}, 32'd0);

    // Randomized episodes, some with a reset in mid-flight.
    for (int ep = 0; ep < 12; ep++) begin
      for (int i = 0; i < 64; i++)
        mem[i] = ($urandom_range(0, 11) == 0) ? 32'hFFFF_FFFF : ($urandom & 32'hFFFF_FFFE);
      do_reset();
      for (int c = 0; c < 60; c++) begin
        if (ep[0] && c == 30) do_reset();
        step("rand", $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, 32'($urandom_range(0, 255)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
